// File: rtl/piso_serializer_stream.sv
// Parallel-in/serial-out serializer with valid/ready on both sides.
// A one-word holding buffer behind the shifter lets back-to-back words stream without idle beats.
module piso_serializer_stream #(
  parameter int WIDTH     = 8,
  parameter bit LSB_FIRST = 1'b0,
  parameter bit FILL_BIT  = 1'b0
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_bit,
  output logic             out_last,
  output logic             busy
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] shift_reg, shift_next;
  logic [WIDTH-1:0] hold_reg, hold_next;
  logic             hold_full_reg, hold_full_next;
  logic [CW-1:0]    cnt_reg, cnt_next;

  logic             accept;
  logic             xfer;
  logic             last_bit;
  logic             head_bit;
  logic [WIDTH-1:0] shift_adv;

  assign in_ready  = !hold_full_reg;
  assign out_valid = (state_reg == SHIFT);
  assign accept    = in_valid && in_ready;
  assign xfer      = out_valid && out_ready;
  assign last_bit  = (cnt_reg == CW'(WIDTH - 1));
  assign out_last  = out_valid && last_bit;
  assign busy      = out_valid || hold_full_reg;

  // The head of the shifter is whichever end is sent first; advancing moves the next bit into it.
  assign head_bit  = LSB_FIRST ? shift_reg[0] : shift_reg[WIDTH-1];
  assign shift_adv = LSB_FIRST ? (shift_reg >> 1) : (shift_reg << 1);
  assign out_bit   = out_valid ? head_bit : FILL_BIT;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_reg     <= IDLE;
      shift_reg     <= '0;
      hold_reg      <= '0;
      hold_full_reg <= 1'b0;
      cnt_reg       <= '0;
    end else begin
      state_reg     <= state_next;
      shift_reg     <= shift_next;
      hold_reg      <= hold_next;
      hold_full_reg <= hold_full_next;
      cnt_reg       <= cnt_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    shift_next     = shift_reg;
    hold_next      = hold_reg;
    hold_full_next = hold_full_reg;
    cnt_next       = cnt_reg;

    case (state_reg)
      IDLE: begin
        if (accept) begin
          shift_next = in_data;
          cnt_next   = '0;
          state_next = SHIFT;
        end
      end

      SHIFT: begin
        if (xfer && last_bit) begin
          // Held word has priority so ordering is preserved; an incoming word then lands in the buffer.
          if (hold_full_reg) begin
            shift_next     = hold_reg;
            cnt_next       = '0;
            hold_full_next = 1'b0;
            if (accept) begin
              hold_next      = in_data;
              hold_full_next = 1'b1;
            end
          end else if (accept) begin
            shift_next = in_data;
            cnt_next   = '0;
          end else begin
            state_next = IDLE;
          end
        end else begin
          if (xfer) begin
            shift_next = shift_adv;
            cnt_next   = cnt_reg + CW'(1);
          end
          if (accept) begin
            hold_next      = in_data;
            hold_full_next = 1'b1;
          end
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_piso_serializer_stream.sv
// Randomized bench for piso_serializer_stream: three instances (8-bit MSB-first, 4-bit LSB-first
// with fill 1, 1-bit) checked every cycle against a bit-queue model of the serial stream.
module tb_piso_serializer_stream;

  logic       clock;
  logic       reset_n;
  logic [2:0] in_valid;
  logic [2:0] in_ready;
  logic [7:0] in_data [3];
  logic [2:0] out_valid;
  logic [2:0] out_ready;
  logic [2:0] out_bit;
  logic [2:0] out_last;
  logic [2:0] busy;

  int checks   = 0;
  int failures = 0;

  // Model: the bits still owed on the serial side, in transmission order.
  bit mq [3][32];
  int mn [3];

  piso_serializer_stream #(.WIDTH(8), .LSB_FIRST(1'b0), .FILL_BIT(1'b0)) u_w8 (
    .clock(clock), .reset_n(reset_n),
    .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_data(in_data[0]),
    .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_bit(out_bit[0]),
    .out_last(out_last[0]), .busy(busy[0])
  );

  piso_serializer_stream #(.WIDTH(4), .LSB_FIRST(1'b1), .FILL_BIT(1'b1)) u_w4 (
    .clock(clock), .reset_n(reset_n),
    .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_data(in_data[1][3:0]),
    .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_bit(out_bit[1]),
    .out_last(out_last[1]), .busy(busy[1])
  );

  piso_serializer_stream #(.WIDTH(1), .LSB_FIRST(1'b0), .FILL_BIT(1'b0)) u_w1 (
    .clock(clock), .reset_n(reset_n),
    .in_valid(in_valid[2]), .in_ready(in_ready[2]), .in_data(in_data[2][0:0]),
    .out_valid(out_valid[2]), .out_ready(out_ready[2]), .out_bit(out_bit[2]),
    .out_last(out_last[2]), .busy(busy[2])
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic int w_of(input int i);
    case (i)
      0:       return 8;
      1:       return 4;
      default: return 1;
    endcase
  endfunction

  function automatic bit lsb_of(input int i);
    return (i == 1);
  endfunction

  function automatic bit fill_of(input int i);
    return (i == 1);
  endfunction

  task automatic chk(input string tag, input int i, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s inst%0d observed=%b expected=%b t=%0t", tag, i, obs, exp, $time);
    end
  endtask

  // Expected outputs follow from the owed-bit count: ceil(mn/W) words are in flight.
  task automatic check_all();
    for (int i = 0; i < 3; i++) begin
      int  w;
      bit  v;
      w = w_of(i);
      v = (mn[i] > 0);
      chk("out_valid", i, out_valid[i], v);
      chk("out_bit",   i, out_bit[i],   v ? mq[i][0] : fill_of(i));
      chk("out_last",  i, out_last[i],  v && (((mn[i] - 1) % w) == 0));
      chk("in_ready",  i, in_ready[i],  mn[i] <= w);
      chk("busy",      i, busy[i],      v);
    end
  endtask

  task automatic model_pop(input int i);
    for (int k = 0; k < mn[i] - 1; k++) mq[i][k] = mq[i][k + 1];
    mn[i]--;
  endtask

  task automatic model_push(input int i, input logic [7:0] d);
    int w;
    w = w_of(i);
    for (int k = 0; k < w; k++) begin
      mq[i][mn[i]] = lsb_of(i) ? d[k] : d[w - 1 - k];
      mn[i]++;
    end
  endtask

  // One clock per iteration: drive, check at the falling edge, update the model after the rising edge.
  task automatic run(input int n, input int pv, input int pr);
    bit acc [3];
    bit xf  [3];
    for (int c = 0; c < n; c++) begin
      for (int i = 0; i < 3; i++) begin
        in_valid[i]  = ($urandom_range(99) < pv);
        in_data[i]   = 8'($urandom);
        out_ready[i] = ($urandom_range(99) < pr);
      end
      @(negedge clock);
      check_all();
      for (int i = 0; i < 3; i++) begin
        acc[i] = in_valid[i] && (mn[i] <= w_of(i));
        xf[i]  = (mn[i] > 0) && out_ready[i];
      end
      @(posedge clock);
      #1;
      for (int i = 0; i < 3; i++) begin
        if (xf[i])  model_pop(i);
        if (acc[i]) model_push(i, in_data[i]);
      end
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 3; i++) mn[i] = 0;
  endtask

  initial begin
    reset_n   = 1'b0;
    in_valid  = '0;
    out_ready = '0;
    for (int i = 0; i < 3; i++) in_data[i] = '0;
    model_clear();
    #12;
    check_all();
    @(negedge clock);
    reset_n = 1'b1;
    @(posedge clock);
    #1;

    run(200, 60, 70);   // mixed traffic
    run(60, 100, 100);  // continuous streaming, both sides always ready
    run(30, 0, 100);    // drain to idle
    run(120, 80, 30);   // heavy backpressure
    run(6, 100, 40);    // fill shifter and buffer

    // Asynchronous reset mid-word: outputs clear at once, nothing is accepted while held.
    reset_n  = 1'b0;
    in_valid = '1;
    model_clear();
    #1;
    check_all();
    @(posedge clock);
    #1;
    check_all();
    @(negedge clock);
    reset_n  = 1'b1;
    in_valid = '0;
    @(posedge clock);
    #1;

    run(150, 60, 60);
    run(30, 0, 100);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/piso_serializer_stream.md
Name: piso_serializer_stream

Overview:
Parametrised parallel-in/serial-out serializer with valid/ready handshakes on both sides. It accepts WIDTH-bit words and shifts them out one bit per accepted serial beat, in a selectable bit order. A one-word holding buffer lets consecutive words stream with no idle beat between them. Sits between word-oriented datapath logic and single-wire serial links, and replaces fixed 4-bit, non-handshaked shift registers.

Parameters:
WIDTH, 8, word width in bits; legal values are 1 or more.
LSB_FIRST, 0, bit order: 0 sends bit WIDTH-1 first, 1 sends bit 0 first.
FILL_BIT, 0, value driven on out_bit whenever out_valid is 0.

Ports:
clock  input  1  single clock; all state changes on the rising edge.
reset_n  input  1  asynchronous reset, active-low.
in_valid  input  1  in_data holds a word offered for loading.
in_ready  output  1  block can accept a word this cycle.
in_data  input  WIDTH  parallel word.
out_valid  output  1  out_bit carries a data bit.
out_ready  input  1  downstream consumes out_bit this cycle.
out_bit  output  1  serial data bit.
out_last  output  1  out_bit is the final bit of the current word.
busy  output  1  a word is in the shifter or in the holding buffer.

Behaviour:
- Reset: while reset_n is 0, asynchronously clear the shifter, the holding buffer and the bit counter. Outputs during and after reset: out_valid=0, out_bit=FILL_BIT, out_last=0, in_ready=1, busy=0. Reset mid-word discards all pending bits and words. The first beat after reset release is normal operation.
- Input accept: a word is accepted on an edge where in_valid and in_ready are both 1. in_ready = !hold_full, which is registered-state combinational. in_ready does not depend on in_valid.
- Output transfer: a bit moves on an edge where out_valid and out_ready are both 1.
- Stall: when out_valid=1 and out_ready=0, out_bit, out_last and the bit counter hold steady.
- Shifter states:
  - IDLE (out_valid=0).
  - SHIFT (out_valid=1, bit_cnt runs from 0 to WIDTH-1).
- Bit order:
  - out_bit is taken combinationally from the shifter's current head bit.
  - With LSB_FIRST=0, the order is in_data[WIDTH-1] down to [0].
  - With LSB_FIRST=1, the order is [0] up to [WIDTH-1].
- out_last = out_valid && (bit_cnt == WIDTH-1).
- Load routing on an accept edge:
  - Load the shifter directly if it is IDLE, or if the final bit is transferring on the same edge and the holding buffer is empty.
  - Otherwise write the word into the holding buffer.
- Final-bit transfer edge:
  - If the holding buffer is full, move the held word into the shifter (bit_cnt=0, stay in SHIFT) and mark the buffer empty.
  - Else, if an accept occurs on the same edge, load the incoming word.
  - Else go to IDLE.
- Simultaneous accept and buffer drain on one edge: the buffer's word goes to the shifter and the incoming word goes to the buffer. No word is lost or reordered.
- Latency: out_valid rises in the cycle after the accept edge into an idle block. Back-to-back words produce WIDTH*N consecutive valid beats with no gap.
- Capacity: two words total (shifter plus buffer). in_ready=0 only while the buffer is full.
- busy = out_valid || hold_full.
- bit_cnt width is clog2(WIDTH), minimum 1.
- WIDTH=1: every valid beat has out_last=1.
- Words are never accepted or transferred while reset_n=0.

Test Plan:
- Bit order, MSB first: WIDTH=4, LSB_FIRST=0, out_ready=1, accept 4'b1011 -> out_bit sequence 1,0,1,1 on consecutive cycles starting the cycle after accept. out_last=1 only on the 4th beat, then out_valid=0 and out_bit=FILL_BIT.
- Bit order, LSB first: WIDTH=4, LSB_FIRST=1, accept 4'b1011 -> out_bit sequence 1,1,0,1, with out_last on the 4th beat.
- Streaming: WIDTH=4, MSB first, offer 4'hA, 4'h5, 4'hF with in_valid held and out_ready=1 -> 12 gap-free valid beats 1010 0101 1111. in_ready drops to 0 while two words are pending. busy falls the cycle after the 12th beat.
- Backpressure: WIDTH=8, accept 8'hC3, drive out_ready=0 for 3 cycles after beat 2 -> out_bit holds the 3rd bit (0) throughout the stall. The full sequence is 1100 0011 and no bit is duplicated or dropped.
- Reset mid-operation: WIDTH=8, after 3 of 8 bits with a second word held, assert reset_n=0 for 1 cycle -> out_valid=0, in_ready=1 and busy=0 immediately. After release, a new word 8'h81 serializes cleanly as 1000 0001.
- Degenerate width: WIDTH=1, accept 1, 0, 1 back-to-back -> out_bit 1,0,1 with out_valid and out_last high on all three beats.
